spi_word_rx: RTL and testbench
==============================

SPI_WORD_RX -- requirements
Module: spi_word_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length in bits (range 2..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for pin inputs (range 2..4).
REQ-003 The block SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RSTN, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port SCK, input, 1, the SPI serial clock from the pin (mode 0: idle low, sample on rising edge), asynchronous to CLK.
REQ-006 The block SHALL have port MOSI, input, 1, the serial data from the pin, MSB first, asynchronous to CLK.
REQ-007 The block SHALL have port CS_N, input, 1, the active-low frame select from the pin, asynchronous to CLK.
REQ-008 The block SHALL have port D, output, WIDTH, the last completed word, registered, feeding the downstream register's D.
REQ-009 The block SHALL have port CE, output, 1, a one-CLK load strobe for D, feeding the downstream register's CE.
REQ-010 The block SHALL have port BUSY, output, 1, high while a frame is active (synchronized CS_N low).
REQ-011 The block SHALL have port FRAME_ERR, output, 1, a one-CLK pulse when a frame ends with a partial word.

Function
REQ-012 SCK, MOSI and CS_N SHALL each pass through SYNC_STAGES flops before use; MOSI SHALL be delayed identically to SCK.
REQ-013 A SCK rising edge SHALL be detected as synchronized SCK = 1 while its previous-cycle value = 0.
REQ-014 The FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT when synchronized CS_N = 0; SHIFT->IDLE when synchronized CS_N = 1.
REQ-015 In SHIFT, each detected SCK rising edge SHALL shift synchronized MOSI into the LSB of a WIDTH-bit shift register and increment the bit counter.
REQ-016 When the counter reaches WIDTH on an edge, the block SHALL load D with the completed word and assert CE on the next CLK cycle for exactly one cycle.
REQ-017 The counter SHALL then wrap to 0 and remain in SHIFT, so back-to-back words within one frame each produce one CE.
REQ-018 D SHALL hold its value between CE pulses and SHALL change only in the cycle CE is high.
REQ-019 A CS_N deassertion with counter != 0 SHALL pulse FRAME_ERR for one cycle, discard the partial word, clear the counter, and not assert CE.
REQ-020 A CS_N deassertion with counter = 0 SHALL return to IDLE without FRAME_ERR.
REQ-021 If the edge that completes a word and the CS_N deassertion are seen in the same cycle, the word SHALL complete (CE asserted) and FRAME_ERR SHALL NOT pulse.
REQ-022 SCK edges seen in IDLE SHALL be ignored.
REQ-023 Correct operation SHALL be guaranteed for SCK high and low times of at least 2 CLK periods each.
REQ-024 BUSY SHALL equal (state == SHIFT).

Reset
REQ-025 RSTN low SHALL immediately force: state IDLE, counter 0, shift register 0, D = 0, CE = 0, BUSY = 0, FRAME_ERR = 0.
REQ-026 On reset, synchronizer flops SHALL take idle pin levels: CS_N stages 1, SCK stages 0, MOSI stages 0.
REQ-027 A reset asserted mid-frame SHALL abort the word silently; no CE or FRAME_ERR SHALL follow release.
REQ-028 After RSTN release, a frame SHALL be accepted only after synchronized CS_N has been seen high at least once, so a frame in progress at release is ignored.

Structure
REQ-029 Package spi_rx_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default WIDTH and SYNC_STAGES constants.
REQ-030 Input synchronization SHALL be a sub-module sync_ff (parameters STAGES, RESET_VALUE; ports CLK, RSTN, A, Y), instantiated once per pin.
REQ-031 All other logic SHALL reside in spi_word_rx; the bit counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-032 WIDTH=8, CLK:SCK = 8:1, one frame sending 0xA5 -> exactly one CE with D = 0xA5; BUSY high for the frame; FRAME_ERR never high.
REQ-033 One frame sending 0x3C then 0xFF back-to-back -> two CE pulses, D = 0x3C then 0xFF, D stable between pulses.
REQ-034 CS_N raised after 5 bits -> one FRAME_ERR pulse, no CE, D keeps its prior value; next full frame with 0x81 -> CE, D = 0x81.
REQ-035 RSTN pulsed low after 4 bits of a frame, with CS_N held low through release -> D = 0, no CE or FRAME_ERR until a new frame after CS_N goes high then low.
REQ-036 SCK toggling with CS_N high -> no CE, BUSY = 0; 8th bit edge and CS_N rise in the same synchronized cycle -> CE asserted, FRAME_ERR = 0.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared types and defaults for the SPI word receiver
package spi_rx_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop pin synchronizer with configurable reset level
module sync_ff #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic A,
  output logic Y
);

  logic [STAGES-1:0] q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) q <= {STAGES{RESET_VALUE}};
    else       q <= {q[STAGES-2:0], A};
  end

  assign Y = q[STAGES-1];

endmodule

// File: rtl/spi_word_rx.sv
// rtl/spi_word_rx.sv - mode-0 SPI slave receiver delivering WIDTH-bit words with a load strobe
module spi_word_rx
  import spi_rx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SCK,
  input  logic             MOSI,
  input  logic             CS_N,
  output logic [WIDTH-1:0] D,
  output logic             CE,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);

  logic sck_s, mosi_s, csn_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .CLK(CLK), .RSTN(RSTN), .A(SCK), .Y(sck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .CLK(CLK), .RSTN(RSTN), .A(MOSI), .Y(mosi_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_csn (
    .CLK(CLK), .RSTN(RSTN), .A(CS_N), .Y(csn_s)
  );

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             sck_q;
  logic             armed;
  logic [FW-1:0]    fill;

  logic             rise;
  logic             word_done;
  logic [WIDTH-1:0] sr_next;

  assign rise      = sck_s & ~sck_q;
  assign word_done = rise && (cnt == LAST);
  assign sr_next   = {sr[WIDTH-2:0], mosi_s};
  assign BUSY      = (state == SHIFT);

  // armed only once csn_s reflects the real pin (synchronizer flushed) and it was high,
  // so a frame already running when reset releases is never picked up mid-way
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      D         <= '0;
      CE        <= 1'b0;
      FRAME_ERR <= 1'b0;
      sck_q     <= 1'b0;
      armed     <= 1'b0;
      fill      <= '0;
    end else begin
      sck_q     <= sck_s;
      CE        <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (fill != FILL_MAX) fill <= fill + FW'(1);
      if (csn_s && (fill == FILL_MAX)) armed <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          sr  <= '0;
          if (!csn_s && armed) state <= SHIFT;
        end
        SHIFT: begin
          if (word_done) begin
            D  <= sr_next;
            CE <= 1'b1;
          end
          if (csn_s) begin
            // a word completing on the closing edge wins over the partial-word error
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            FRAME_ERR <= !word_done && (rise || (cnt != '0));
          end else if (rise) begin
            sr  <= sr_next;
            cnt <= word_done ? '0 : cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_rx.sv
// tb/tb_spi_word_rx.sv - self-checking bench for spi_word_rx
module tb_spi_word_rx;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       SCK;
  logic       MOSI;
  logic       CS_N;
  logic [7:0] D;
  logic       CE;
  logic       BUSY;
  logic       FRAME_ERR;

  spi_word_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
    .D(D), .CE(CE), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] expq[$];
  logic [7:0] prev_d = 8'h00;

  typedef struct {
    int          nbits;
    logic [31:0] data;
    int          exp_ce;
    int          exp_ferr;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every CE is matched against the next word the reference model predicted
  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_d = 8'h00;
    end else begin
      if (CE) begin
        ce_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ce_unexpected: got CE with D=%0h expected no CE", D);
        end else begin
          chk("ce_data", {24'h0, D}, {24'h0, expq.pop_front()});
        end
      end else if (D !== prev_d) begin
        chk("d_hold", {24'h0, D}, {24'h0, prev_d});
      end
      if (FRAME_ERR) ferr_cnt++;
      prev_d = D;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bit_tx(input logic b);
    SCK  = 1'b0;
    MOSI = b;
    wclk(4);
    SCK = 1'b1;
    wclk(4);
    SCK = 1'b0;
  endtask

  // reference: a frame of n bits yields floor(n/8) MSB-first words and an error iff n%8 != 0
  function automatic logic [7:0] word_k(input logic [31:0] data, input int nbits, input int k);
    logic [31:0] t;
    t = data >> (nbits - 8 * (k + 1));
    return t[7:0];
  endfunction

  task automatic send_frame(input int nbits, input logic [31:0] data);
    CS_N = 1'b0;
    wclk(4);
    chk("busy_in_frame", {31'h0, BUSY}, 32'h1);
    for (int i = nbits - 1; i >= 0; i--) bit_tx(data[i]);
    wclk(4);
    CS_N = 1'b1;
    wclk(8);
    chk("busy_after_frame", {31'h0, BUSY}, 32'h0);
  endtask

  initial begin
    logic [7:0] model_d;
    int ce0, fe0;

    vecs[0] = '{8,  32'hA5,   1, 0, 8'hA5};
    vecs[1] = '{16, 32'h3CFF, 2, 0, 8'hFF};
    vecs[2] = '{5,  32'h15,   0, 1, 8'hFF};
    vecs[3] = '{8,  32'h81,   1, 0, 8'h81};
    vecs[4] = '{0,  32'h0,    0, 0, 8'h81};
    model_d = 8'h81;
    for (int i = 5; i < 16; i++) begin
      int n;
      logic [31:0] d;
      n = $urandom_range(1, 24);
      d = $urandom() & ((32'h1 << n) - 32'h1);
      vecs[i].nbits    = n;
      vecs[i].data     = d;
      vecs[i].exp_ce   = n / 8;
      vecs[i].exp_ferr = (n % 8 != 0) ? 1 : 0;
      if (n >= 8) model_d = word_k(d, n, n / 8 - 1);
      vecs[i].exp_d    = model_d;
    end

    RSTN = 1'b0;
    CS_N = 1'b1;
    SCK  = 1'b0;
    MOSI = 1'b0;
    wclk(3);
    chk("rst_d", {24'h0, D}, 32'h0);
    chk("rst_ce", {31'h0, CE}, 32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_ferr", {31'h0, FRAME_ERR}, 32'h0);
    RSTN = 1'b1;
    wclk(6);

    for (int i = 0; i < 16; i++) begin
      ce0 = ce_cnt;
      fe0 = ferr_cnt;
      for (int k = 0; k < vecs[i].nbits / 8; k++)
        expq.push_back(word_k(vecs[i].data, vecs[i].nbits, k));
      send_frame(vecs[i].nbits, vecs[i].data);
      chk($sformatf("vec%0d_ce", i), ce_cnt - ce0, vecs[i].exp_ce);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - fe0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_d", i), {24'h0, D}, {24'h0, vecs[i].exp_d});
    end

    // SCK activity with CS_N high must be ignored
    ce0 = ce_cnt;
    fe0 = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      bit_tx(i[0]);
      if (i == 4) chk("idle_busy", {31'h0, BUSY}, 32'h0);
    end
    wclk(8);
    chk("idle_ce", ce_cnt - ce0, 0);
    chk("idle_ferr", ferr_cnt - fe0, 0);

    // final edge and CS_N rise land in the same synchronized cycle
    ce0 = ce_cnt;
    fe0 = ferr_cnt;
    expq.push_back(8'h6B);
    CS_N = 1'b0;
    wclk(4);
    for (int i = 7; i >= 1; i--) bit_tx(((8'h6B >> i) & 8'h1) != 0);
    SCK  = 1'b0;
    MOSI = 1'b1;
    wclk(4);
    SCK  = 1'b1;
    CS_N = 1'b1;
    wclk(4);
    SCK = 1'b0;
    wclk(8);
    chk("sim_ce", ce_cnt - ce0, 1);
    chk("sim_ferr", ferr_cnt - fe0, 0);
    chk("sim_d", {24'h0, D}, 32'h6B);

    // reset mid-frame with CS_N held low through release
    CS_N = 1'b0;
    wclk(4);
    for (int i = 0; i < 4; i++) bit_tx(1'b1);
    RSTN = 1'b0;
    #2;
    chk("midrst_d", {24'h0, D}, 32'h0);
    chk("midrst_busy", {31'h0, BUSY}, 32'h0);
    wclk(2);
    RSTN = 1'b1;
    ce0 = ce_cnt;
    fe0 = ferr_cnt;
    for (int i = 0; i < 8; i++) bit_tx(i[1]);
    wclk(4);
    chk("midrst_busy_after", {31'h0, BUSY}, 32'h0);
    CS_N = 1'b1;
    wclk(8);
    chk("midrst_ce", ce_cnt - ce0, 0);
    chk("midrst_ferr", ferr_cnt - fe0, 0);
    chk("midrst_d_hold", {24'h0, D}, 32'h0);

    ce0 = ce_cnt;
    expq.push_back(8'h81);
    send_frame(8, 32'h81);
    chk("post_rst_ce", ce_cnt - ce0, 1);
    chk("post_rst_d", {24'h0, D}, 32'h81);

    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
